// File: rtl/harmonic_pkg.sv
// Shared definitions for the harmonic multiplier sequencer: default widths,
// the derived accumulator width and the sequencer state encoding.
package harmonic_pkg;

   localparam int DEF_DIV_BIT  = 9;
   localparam int DEF_SAMPLE_W = 16;
   localparam int DEF_HARM_BIT = 7;
   localparam int ACC_W        = DEF_SAMPLE_W + DEF_HARM_BIT;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RESTART,
      ST_WAIT,
      ST_GUARD1,
      ST_GUARD2,
      ST_DONE
   } seq_state_t;

   // Sum of up to 2^harm_bit-1 sample-width terms never overflows this width.
   function automatic int acc_width(input int sample_w, input int harm_bit);
      return sample_w + harm_bit;
   endfunction

endpackage

// File: rtl/harmonic_mac.sv
// Weighted accumulator: adds floor((sine * multiple) / 2^DIV_BIT) per enable,
// synchronous clear, and exposes the value the register will take next.
import harmonic_pkg::*;

module harmonic_mac #(
   parameter int DIV_BIT  = DEF_DIV_BIT,
   parameter int SAMPLE_W = DEF_SAMPLE_W,
   parameter int SUM_W    = ACC_W
) (
   input  logic                i_Clock,
   input  logic                i_Reset_n,
   input  logic                clear,
   input  logic                enable,
   input  logic [SAMPLE_W-1:0] sine,
   input  logic [DIV_BIT-1:0]  mult,
   output logic [SUM_W-1:0]    sum_next
);

   localparam int PROD_W = SAMPLE_W + DIV_BIT + 1;

   logic signed [PROD_W-1:0]   product;
   logic signed [SAMPLE_W-1:0] term;
   logic signed [SUM_W-1:0]    term_ext;
   logic        [SUM_W-1:0]    acc;

   // The multiple is unsigned, so it gets a zero sign bit before the signed
   // multiply; the arithmetic shift then rounds toward minus infinity.
   always_comb begin
      product  = PROD_W'($signed(sine)) * PROD_W'($signed({1'b0, mult}));
      term     = SAMPLE_W'(product >>> DIV_BIT);
      term_ext = SUM_W'(term);
      if (clear) begin
         sum_next = '0;
      end else if (enable) begin
         sum_next = acc + term_ext;
      end else begin
         sum_next = acc;
      end
   end

   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         acc <= '0;
      end else begin
         acc <= sum_next;
      end
   end

endmodule

// File: rtl/harmonic_mult_sequencer.sv
// Per-sample-tick sequencer: restarts the scale multiplier, walks harmonics
// 0..N-1 stepping it with Start pulses, and emits the summed additive sample.
import harmonic_pkg::*;

module harmonic_mult_sequencer #(
   parameter int DIV_BIT  = DEF_DIV_BIT,
   parameter int SAMPLE_W = DEF_SAMPLE_W,
   parameter int HARM_BIT = DEF_HARM_BIT
) (
   input  logic                         i_Clock,
   input  logic                         i_Reset_n,
   input  logic                         i_Sample_Tick,
   input  logic [HARM_BIT-1:0]          i_Harmonics,
   output logic                         o_Restart,
   output logic                         o_Start,
   input  logic [DIV_BIT-1:0]           i_Mult,
   input  logic                         i_Mult_Ready,
   output logic [HARM_BIT-1:0]          o_Harmonic,
   input  logic [SAMPLE_W-1:0]          i_Sine,
   output logic [SAMPLE_W+HARM_BIT-1:0] o_Sample,
   output logic                         o_Sample_Valid,
   output logic                         o_Overrun
);

   localparam int SUM_W = acc_width(SAMPLE_W, HARM_BIT);
   localparam logic [HARM_BIT-1:0] HARM_ONE = HARM_BIT'(1);

   seq_state_t state_q, state_d;

   logic [HARM_BIT-1:0] n_q, n_d;
   logic [HARM_BIT-1:0] harm_q, harm_d;
   logic                restart_q, restart_d;
   logic                start_q, start_d;
   logic                valid_q, valid_d;
   logic                overrun_q, overrun_d;
   logic [SUM_W-1:0]    sample_q;
   logic                mac_clear, mac_enable;
   logic [SUM_W-1:0]    sum_next;
   logic                last_harm;

   assign last_harm = (harm_q + HARM_ONE) == n_q;

   harmonic_mac #(
      .DIV_BIT  (DIV_BIT),
      .SAMPLE_W (SAMPLE_W),
      .SUM_W    (SUM_W)
   ) u_mac (
      .i_Clock   (i_Clock),
      .i_Reset_n (i_Reset_n),
      .clear     (mac_clear),
      .enable    (mac_enable),
      .sine      (i_Sine),
      .mult      (i_Mult),
      .sum_next  (sum_next)
   );

   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Pulse outputs are decoded from the transition so they appear in the
   // same cycle as the state they belong to while still coming from flops.
   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      harm_d     = harm_q;
      restart_d  = 1'b0;
      start_d    = 1'b0;
      valid_d    = 1'b0;
      overrun_d  = i_Sample_Tick && (state_q != ST_IDLE);
      mac_clear  = 1'b0;
      mac_enable = 1'b0;
      case (state_q)
         ST_IDLE: begin
            harm_d = '0;
            if (i_Sample_Tick) begin
               n_d       = i_Harmonics;
               mac_clear = 1'b1;
               if (i_Harmonics == '0) begin
                  state_d = ST_DONE;
                  valid_d = 1'b1;
               end else begin
                  state_d   = ST_RESTART;
                  restart_d = 1'b1;
               end
            end
         end
         ST_RESTART: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (i_Mult_Ready) begin
               mac_enable = 1'b1;
               if (last_harm) begin
                  state_d = ST_DONE;
                  valid_d = 1'b1;
               end else begin
                  state_d = ST_GUARD1;
                  start_d = 1'b1;
                  harm_d  = harm_q + HARM_ONE;
               end
            end
         end
         // Ready is stale while the multiplier digests Start; never sample it here.
         ST_GUARD1: begin
            state_d = ST_GUARD2;
         end
         ST_GUARD2: begin
            state_d = ST_WAIT;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            harm_d  = '0;
         end
         default: begin
            state_d = ST_IDLE;
            harm_d  = '0;
         end
      endcase
   end

   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         n_q       <= '0;
         harm_q    <= '0;
         restart_q <= 1'b0;
         start_q   <= 1'b0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         sample_q  <= '0;
      end else begin
         n_q       <= n_d;
         harm_q    <= harm_d;
         restart_q <= restart_d;
         start_q   <= start_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
         if (valid_d) begin
            sample_q <= sum_next;
         end
      end
   end

   assign o_Restart      = restart_q;
   assign o_Start        = start_q;
   assign o_Harmonic     = harm_q;
   assign o_Sample       = sample_q;
   assign o_Sample_Valid = valid_q;
   assign o_Overrun      = overrun_q;

endmodule

// File: tb/tb_harmonic_mult_sequencer.sv
// Self-checking bench for harmonic_mult_sequencer: directed frame table,
// reset-mid-frame sequence and randomized frames against a reference sum.
module tb_harmonic_mult_sequencer;

   localparam int DIV_BIT  = 9;
   localparam int SAMPLE_W = 16;
   localparam int HARM_BIT = 7;
   localparam int SUM_W    = SAMPLE_W + HARM_BIT;

   logic                       i_Clock;
   logic                       i_Reset_n;
   logic                       i_Sample_Tick;
   logic [HARM_BIT-1:0]        i_Harmonics;
   logic                       o_Restart;
   logic                       o_Start;
   logic [DIV_BIT-1:0]         i_Mult;
   logic                       i_Mult_Ready;
   logic [HARM_BIT-1:0]        o_Harmonic;
   logic [SAMPLE_W-1:0]        i_Sine;
   logic signed [SUM_W-1:0]    o_Sample;
   logic                       o_Sample_Valid;
   logic                       o_Overrun;

   int compared   = 0;
   int mismatched = 0;

   int mdl_init;
   int mdl_scale;
   int mdl_stall_idx;
   int mdl_stall_extra;
   int low_cnt;
   int start_cnt;

   logic signed [SAMPLE_W-1:0] sine_lut [128];

   typedef struct {
      string  name;
      int     sine;
      int     init_mult;
      int     scale;
      int     n;
      int     stall_idx;
      int     stall_extra;
      int     ovr_cycle;
      longint exp_sample;
      int     exp_lat;
      int     exp_restart;
      int     exp_start;
      int     exp_ovr;
   } vec_t;

   vec_t vectors [7];

   harmonic_mult_sequencer #(
      .DIV_BIT  (DIV_BIT),
      .SAMPLE_W (SAMPLE_W),
      .HARM_BIT (HARM_BIT)
   ) dut (
      .i_Clock        (i_Clock),
      .i_Reset_n      (i_Reset_n),
      .i_Sample_Tick  (i_Sample_Tick),
      .i_Harmonics    (i_Harmonics),
      .o_Restart      (o_Restart),
      .o_Start        (o_Start),
      .i_Mult         (i_Mult),
      .i_Mult_Ready   (i_Mult_Ready),
      .o_Harmonic     (o_Harmonic),
      .i_Sine         (i_Sine),
      .o_Sample       (o_Sample),
      .o_Sample_Valid (o_Sample_Valid),
      .o_Overrun      (o_Overrun)
   );

   initial i_Clock = 1'b0;
   always #5 i_Clock = ~i_Clock;

   // Registered sine LUT: one cycle from o_Harmonic to i_Sine.
   always @(posedge i_Clock) begin
      i_Sine <= sine_lut[o_Harmonic];
   end

   // Scale multiplier: restart loads the initial multiple; Start drops Ready
   // for one cycle (plus an optional stall) and reduces the multiple, floored at 0.
   always @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         i_Mult       <= '0;
         i_Mult_Ready <= 1'b0;
         low_cnt      <= 0;
         start_cnt    <= 0;
      end else if (o_Restart) begin
         i_Mult       <= DIV_BIT'(mdl_init);
         i_Mult_Ready <= 1'b1;
         low_cnt      <= 0;
         start_cnt    <= 0;
      end else if (o_Start) begin
         i_Mult       <= (int'(i_Mult) >= mdl_scale) ? DIV_BIT'(int'(i_Mult) - mdl_scale) : '0;
         i_Mult_Ready <= 1'b0;
         low_cnt      <= (start_cnt == mdl_stall_idx) ? mdl_stall_extra : 0;
         start_cnt    <= start_cnt + 1;
      end else if (!i_Mult_Ready) begin
         if (low_cnt == 0) begin
            i_Mult_Ready <= 1'b1;
         end else begin
            low_cnt <= low_cnt - 1;
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Sum of floor(sine[h] * multiple_h / 2^DIV_BIT), multiple_h = max(init - h*scale, 0).
   function automatic longint refSample(input int n, input int init_mult, input int scale);
      longint acc = 0;
      for (int h = 0; h < n; h++) begin
         longint m = longint'(init_mult) - longint'(h) * longint'(scale);
         longint p;
         longint q;
         if (m < 0) m = 0;
         p = longint'(sine_lut[h]) * m;
         q = p / (longint'(1) << DIV_BIT);
         if (p < 0 && (p % (longint'(1) << DIV_BIT)) != 0) q = q - 1;
         acc += q;
      end
      return acc;
   endfunction

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic fillLut(input int value);
      for (int h = 0; h < 128; h++) sine_lut[h] = SAMPLE_W'(value);
   endtask

   task automatic applyStimulus(input vec_t v);
      int cyc;
      int restarts = 0;
      int starts   = 0;
      int ovrs     = 0;
      mdl_init        = v.init_mult;
      mdl_scale       = v.scale;
      mdl_stall_idx   = v.stall_idx;
      mdl_stall_extra = v.stall_extra;
      i_Harmonics     = HARM_BIT'(v.n);
      i_Sample_Tick   = 1'b1;
      @(posedge i_Clock); #1;
      i_Sample_Tick = 1'b0;
      i_Harmonics   = HARM_BIT'($urandom);
      cyc = 1;
      while (1) begin
         restarts += int'(o_Restart);
         starts   += int'(o_Start);
         ovrs     += int'(o_Overrun);
         if (v.ovr_cycle > 0 && cyc == v.ovr_cycle + 1)
            checkOutput({v.name, ".overrun_timing"}, longint'(o_Overrun), 1);
         if (o_Sample_Valid || cyc >= 400) begin
            i_Sample_Tick = 1'b0;
            break;
         end
         i_Sample_Tick = (v.ovr_cycle > 0 && cyc == v.ovr_cycle);
         @(posedge i_Clock); #1;
         cyc++;
      end
      checkOutput({v.name, ".valid_seen"}, longint'(o_Sample_Valid), 1);
      checkOutput({v.name, ".sample"}, longint'(o_Sample), v.exp_sample);
      checkOutput({v.name, ".latency"}, longint'(cyc), longint'(v.exp_lat));
      checkOutput({v.name, ".restarts"}, longint'(restarts), longint'(v.exp_restart));
      checkOutput({v.name, ".starts"}, longint'(starts), longint'(v.exp_start));
      checkOutput({v.name, ".overruns"}, longint'(ovrs), longint'(v.exp_ovr));
      @(posedge i_Clock); #1;
      checkOutput({v.name, ".valid_drop"}, longint'(o_Sample_Valid), 0);
      checkOutput({v.name, ".sample_hold"}, longint'(o_Sample), v.exp_sample);
   endtask

   initial begin
      vectors[0] = '{"n4_pos",   1000, 256,  64, 4, -1, 0, 0, 1250, 12, 1, 3, 0};
      vectors[1] = '{"n1_floor", -1000,  1,  64, 1, -1, 0, 0,   -2,  3, 1, 0, 0};
      vectors[2] = '{"n0",       1000, 256,  64, 0, -1, 0, 0,    0,  1, 0, 0, 0};
      vectors[3] = '{"stall",    1000, 256,  64, 4,  1, 5, 0, 1250, 17, 1, 3, 0};
      vectors[4] = '{"overrun",  1000, 256,  64, 4, -1, 0, 4, 1250, 12, 1, 3, 1};
      vectors[5] = '{"n6_mix",    300, 511, 100, 6, -1, 0, 0,  915, 18, 1, 5, 0};
      vectors[6] = '{"zero_flr", -500, 100,  64, 3, -1, 0, 0, -134,  9, 1, 2, 0};

      i_Reset_n       = 1'b0;
      i_Sample_Tick   = 1'b0;
      i_Harmonics     = '0;
      mdl_init        = 0;
      mdl_scale       = 0;
      mdl_stall_idx   = -1;
      mdl_stall_extra = 0;
      fillLut(0);

      repeat (3) @(posedge i_Clock);
      #1;
      checkOutput("reset.restart", longint'(o_Restart), 0);
      checkOutput("reset.start", longint'(o_Start), 0);
      checkOutput("reset.harmonic", longint'(o_Harmonic), 0);
      checkOutput("reset.sample", longint'(o_Sample), 0);
      checkOutput("reset.valid", longint'(o_Sample_Valid), 0);
      checkOutput("reset.overrun", longint'(o_Overrun), 0);
      i_Reset_n = 1'b1;
      @(posedge i_Clock); #1;

      for (int i = 0; i < 7; i++) begin
         fillLut(vectors[i].sine);
         applyStimulus(vectors[i]);
      end

      // Reset while in GUARD1 of an N=4 frame, then a clean frame afterwards.
      fillLut(1000);
      mdl_init        = 256;
      mdl_scale       = 64;
      mdl_stall_idx   = -1;
      mdl_stall_extra = 0;
      i_Harmonics     = HARM_BIT'(4);
      i_Sample_Tick   = 1'b1;
      @(posedge i_Clock); #1;
      i_Sample_Tick = 1'b0;
      repeat (2) @(posedge i_Clock);
      #1;
      checkOutput("guard1.start", longint'(o_Start), 1);
      checkOutput("guard1.harmonic", longint'(o_Harmonic), 1);
      i_Reset_n = 1'b0;
      #1;
      checkOutput("midreset.start", longint'(o_Start), 0);
      checkOutput("midreset.harmonic", longint'(o_Harmonic), 0);
      checkOutput("midreset.sample", longint'(o_Sample), 0);
      checkOutput("midreset.restart", longint'(o_Restart), 0);
      checkOutput("midreset.valid", longint'(o_Sample_Valid), 0);
      @(posedge i_Clock); #1;
      i_Reset_n = 1'b1;
      @(posedge i_Clock); #1;
      applyStimulus(vectors[0]);

      for (int r = 0; r < 10; r++) begin
         vec_t v;
         v.n           = $urandom_range(1, 8);
         for (int h = 0; h < 128; h++) sine_lut[h] = SAMPLE_W'($urandom);
         v.name        = $sformatf("rand%0d", r);
         v.sine        = 0;
         v.init_mult   = $urandom_range(0, 511);
         v.scale       = $urandom_range(0, 200);
         v.stall_idx   = $urandom_range(0, 6);
         v.stall_extra = $urandom_range(0, 4);
         v.ovr_cycle   = 0;
         v.exp_sample  = refSample(v.n, v.init_mult, v.scale);
         v.exp_lat     = 3 * v.n + ((v.stall_idx <= v.n - 2) ? v.stall_extra : 0);
         v.exp_restart = 1;
         v.exp_start   = v.n - 1;
         v.exp_ovr     = 0;
         applyStimulus(v);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
